// File: rtl/network_bf_in_nlane.sv
// network_bf_in_nlane: N-lane bank-to-butterfly permutation network with delayed select and valid tracking
module network_bf_in_nlane #(
  parameter int DATA_WIDTH = 14,
  parameter int LANES      = 4,
  parameter int SEL_DELAY  = 1,
  parameter int OUT_REG    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [$clog2(LANES)-1:0]      sel,
  input  logic                          mode,
  input  logic                          sel_valid,
  input  logic [LANES*DATA_WIDTH-1:0]   q,
  output logic [LANES*DATA_WIDTH-1:0]   u,
  output logic                          out_valid
);
  localparam int SW = $clog2(LANES);
  logic [SEL_DELAY-1:0][SW-1:0] sel_q;
  logic [SEL_DELAY-1:0]         mode_q;
  logic [SEL_DELAY-1:0]         vld_q;
  logic [SW-1:0]                sel_d;
  logic                         mode_d;
  logic                         vld_d;
  logic [LANES*DATA_WIDTH-1:0]  perm;
  assign sel_d  = sel_q[SEL_DELAY-1];
  assign mode_d = mode_q[SEL_DELAY-1];
  assign vld_d  = vld_q[SEL_DELAY-1];
  // select/mode/valid delay line aligning the select with bank read data; flush kills in-flight valids
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_q  <= '0;
      mode_q <= '0;
      vld_q  <= '0;
    end else begin
      sel_q[0]  <= sel;
      mode_q[0] <= mode;
      vld_q[0]  <= sel_valid & ~flush;
      for (int k = 1; k < SEL_DELAY; k++) begin
        sel_q[k]  <= sel_q[k-1];
        mode_q[k] <= mode_q[k-1];
        vld_q[k]  <= vld_q[k-1] & ~flush;
      end
    end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [SW-1:0] idx;
    assign idx = mode_d ? (SW'(g) ^ sel_d) : (SW'(g) + sel_d);
    assign perm[g*DATA_WIDTH +: DATA_WIDTH] = q[idx*DATA_WIDTH +: DATA_WIDTH];
  end
  if (OUT_REG != 0) begin : g_reg
    logic [LANES*DATA_WIDTH-1:0] u_q;
    logic                        ov_q;
    // output register captures only valid permuted words and holds otherwise
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        u_q  <= '0;
        ov_q <= 1'b0;
      end else begin
        if (vld_d & ~flush) u_q <= perm;
        ov_q <= vld_d & ~flush;
      end
    assign u         = u_q;
    assign out_valid = ov_q;
  end else begin : g_comb
    assign u         = perm;
    assign out_valid = vld_d;
  end
endmodule

// File: tb/tb_network_bf_in_nlane.sv
// tb_network_bf_in_nlane: directed scoreboard bench covering rotate/xor modes, legacy swap, flush and reset
module tb_network_bf_in_nlane;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic fa = 0, ma = 0, va = 0;
  logic [1:0] sa = 0;
  logic [55:0] qa = 0, ua;
  logic ova;
  logic fb = 0, mb = 0, vb = 0, sb = 0;
  logic [27:0] qb = {14'h0111, 14'h0222}, ub;
  logic ovb;
  logic fc = 0, mc = 0, vc = 0;
  logic [1:0] sc = 0;
  logic [55:0] qc = 0, uc;
  logic ovc;

  network_bf_in_nlane dut_a (.clk(clk), .rst(rst), .flush(fa), .sel(sa), .mode(ma),
    .sel_valid(va), .q(qa), .u(ua), .out_valid(ova));
  network_bf_in_nlane #(.LANES(2), .OUT_REG(0)) dut_b (.clk(clk), .rst(rst), .flush(fb),
    .sel(sb), .mode(mb), .sel_valid(vb), .q(qb), .u(ub), .out_valid(ovb));
  network_bf_in_nlane #(.SEL_DELAY(3)) dut_c (.clk(clk), .rst(rst), .flush(fc), .sel(sc),
    .mode(mc), .sel_valid(vc), .q(qc), .u(uc), .out_valid(ovc));

  int total = 0, bad = 0;
  logic [55:0] sba[$], sbc[$];
  logic [1:0] ps = 0;
  logic pm = 0, pv = 0;

  localparam logic [55:0] QD   = {14'h0D, 14'h0C, 14'h0B, 14'h0A};
  localparam logic [55:0] ROT0 = {14'h0D, 14'h0C, 14'h0B, 14'h0A};
  localparam logic [55:0] ROT1 = {14'h0A, 14'h0D, 14'h0C, 14'h0B};
  localparam logic [55:0] ROT2 = {14'h0B, 14'h0A, 14'h0D, 14'h0C};
  localparam logic [55:0] ROT3 = {14'h0C, 14'h0B, 14'h0A, 14'h0D};
  localparam logic [55:0] XOR3 = {14'h0A, 14'h0B, 14'h0C, 14'h0D};
  localparam logic [55:0] XOR2 = {14'h0B, 14'h0A, 14'h0D, 14'h0C};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] perm4(input logic [55:0] q, input logic [1:0] s, input logic m);
    logic [1:0] k;
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      k = m ? (2'(i) ^ s) : 2'((i + int'(s)) % 4);
      r[i*14 +: 14] = q[k*14 +: 14];
    end
    return r;
  endfunction

  task automatic issue_a(input logic [1:0] s, input logic m, input logic v, input logic [55:0] q);
    qa = q;
    if (pv) sba.push_back(perm4(q, ps, pm));
    sa = s; ma = m; va = v;
    ps = s; pm = m; pv = v;
    tick;
  endtask

  always @(negedge clk)
    if (!rst && ova) begin
      if (sba.size() == 0) chk("a_extra_valid", 64'(ova), 64'd0);
      else chk("a_sb_u", 64'(ua), 64'(sba.pop_front()));
    end

  always @(negedge clk)
    if (!rst && ovc) begin
      if (sbc.size() == 0) chk("c_extra_valid", 64'(ovc), 64'd0);
      else chk("c_sb_u", 64'(uc), 64'(sbc.pop_front()));
    end

  initial begin
    tick;
    @(negedge clk);
    chk("rst_ua", 64'(ua), 64'd0);
    chk("rst_ova", 64'(ova), 64'd0);
    chk("rst_ovc", 64'(ovc), 64'd0);
    chk("rst_ub_ident", 64'(ub), 64'(qb));
    chk("rst_ovb", 64'(ovb), 64'd0);
    tick;
    rst = 0;
    tick;
    issue_a(2'd1, 1'b0, 1'b1, 56'd0);
    issue_a(2'd3, 1'b1, 1'b1, QD);
    @(negedge clk);
    chk("rot1_u", 64'(ua), 64'(ROT1));
    chk("rot1_v", 64'(ova), 64'd1);
    issue_a(2'd0, 1'b0, 1'b1, QD);
    @(negedge clk);
    chk("xor3_u", 64'(ua), 64'(XOR3));
    issue_a(2'd1, 1'b0, 1'b1, QD);
    @(negedge clk);
    chk("b2b_rot0", 64'(ua), 64'(ROT0));
    chk("b2b_v0", 64'(ova), 64'd1);
    issue_a(2'd2, 1'b0, 1'b1, QD);
    @(negedge clk);
    chk("b2b_rot1", 64'(ua), 64'(ROT1));
    chk("b2b_v1", 64'(ova), 64'd1);
    issue_a(2'd3, 1'b0, 1'b1, QD);
    @(negedge clk);
    chk("b2b_rot2", 64'(ua), 64'(ROT2));
    chk("b2b_v2", 64'(ova), 64'd1);
    issue_a(2'd0, 1'b0, 1'b0, QD);
    @(negedge clk);
    chk("b2b_rot3", 64'(ua), 64'(ROT3));
    chk("b2b_v3", 64'(ova), 64'd1);
    issue_a(2'd0, 1'b0, 1'b0, 56'd0);
    @(negedge clk);
    chk("idle_v", 64'(ova), 64'd0);
    chk("idle_hold_u", 64'(ua), 64'(ROT3));

    sb = 1; vb = 1; qb = 0;
    tick;
    sb = 0; vb = 0; qb = {14'h0567, 14'h1234};
    @(negedge clk);
    chk("swap_u", 64'(ub), 64'({14'h1234, 14'h0567}));
    chk("swap_v", 64'(ovb), 64'd1);
    tick;
    @(negedge clk);
    chk("swap_after_v", 64'(ovb), 64'd0);
    chk("swap_after_ident", 64'(ub), 64'(qb));

    sb = 1; vb = 1;
    issue_a(2'd2, 1'b1, 1'b1, 56'd0);
    sb = 0; vb = 0; va = 0; pv = 0;
    qa = QD; qb = {14'h0AAA, 14'h0555};
    rst = 1;
    #1;
    chk("midrst_ua", 64'(ua), 64'd0);
    chk("midrst_ova", 64'(ova), 64'd0);
    chk("midrst_ovb", 64'(ovb), 64'd0);
    chk("midrst_ub_ident", 64'(ub), 64'(qb));
    tick;
    rst = 0;
    @(negedge clk);
    chk("postrst_ova", 64'(ova), 64'd0);
    chk("postrst_ovb", 64'(ovb), 64'd0);
    chk("postrst_ub_ident", 64'(ub), 64'(qb));
    tick;
    @(negedge clk);
    chk("postrst2_ova", 64'(ova), 64'd0);
    chk("postrst2_ub_ident", 64'(ub), 64'(qb));
    issue_a(2'd2, 1'b1, 1'b1, 56'd0);
    issue_a(2'd0, 1'b0, 1'b0, QD);
    @(negedge clk);
    chk("newsel_u", 64'(ua), 64'(XOR2));
    chk("newsel_v", 64'(ova), 64'd1);

    vc = 1; sc = 1;
    tick;
    vc = 0;
    @(negedge clk);
    chk("c_v1", 64'(ovc), 64'd0);
    tick;
    fc = 1; vc = 1; sc = 3;
    @(negedge clk);
    chk("c_v2", 64'(ovc), 64'd0);
    tick;
    fc = 0; vc = 1; sc = 2; mc = 0;
    @(negedge clk);
    chk("c_v3", 64'(ovc), 64'd0);
    tick;
    vc = 0;
    @(negedge clk);
    chk("c_v4", 64'(ovc), 64'd0);
    tick;
    @(negedge clk);
    chk("c_v5", 64'(ovc), 64'd0);
    tick;
    qc = QD;
    sbc.push_back(perm4(QD, 2'd2, 1'b0));
    @(negedge clk);
    chk("c_v6", 64'(ovc), 64'd0);
    tick;
    qc = 0;
    @(negedge clk);
    chk("c_v7", 64'(ovc), 64'd1);
    chk("c_u7", 64'(uc), 64'(ROT2));
    tick;
    @(negedge clk);
    chk("c_v8", 64'(ovc), 64'd0);

    tick;
    chk("a_sb_empty", 64'(sba.size()), 64'd0);
    chk("c_sb_empty", 64'(sbc.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/network_bf_in_nlane.md
Name: network_bf_in_nlane

Overview:
- Parametrised input permutation network for the NTT butterfly array.
- Takes LANES words read in parallel from LANES memory banks and reorders them into butterfly operand order.
- The select is issued alongside the bank read address. It is delayed internally by SEL_DELAY cycles so that it aligns with the read data.
- Generalises the two-lane swap network to N lanes, configurable read latency, two permutation modes, valid tracking and an optional output register.

Parameters:
- DATA_WIDTH, 14, width of one coefficient word.
- LANES, 4, number of banks/lanes; power of 2, at least 2.
- SEL_DELAY, 1, cycles between select issue and matching bank data; at least 1.
- OUT_REG, 1, 1 = registered outputs (+1 cycle latency), 0 = combinational outputs.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- flush  in  1  synchronous clear of the valid pipeline.
- sel  in  log2(LANES)  permutation amount, issued with the bank read.
- mode  in  1  0 = rotate, 1 = xor-index.
- sel_valid  in  1  marks sel/mode as belonging to a real read.
- q  in  LANES*DATA_WIDTH  bank read data; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- u  out  LANES*DATA_WIDTH  permuted butterfly operands, same packing as q.
- out_valid  out  1  u holds a valid permuted word.

Behaviour:
- Delay line: sel, mode and sel_valid enter a shift register of depth SEL_DELAY every cycle, unconditionally. The taps at the end are sel_d, mode_d and vld_d.
- Permutation (combinational on q, sel_d, mode_d), for each output lane i:
  - mode_d=0: u[i] = q[(i + sel_d) mod LANES].
  - mode_d=1: u[i] = q[i XOR sel_d].
  - With LANES=2, both modes reduce to the legacy swap: sel_d=0 gives u0=q0, u1=q1; sel_d=1 gives u0=q1, u1=q0.
- OUT_REG=1:
  - The u register loads the permuted word only when vld_d=1; otherwise it holds its value.
  - out_valid <= vld_d & ~flush.
  - Latency from sel issue to u: SEL_DELAY+1 cycles. q at cycle t appears on u at t+1.
- OUT_REG=0:
  - u is the combinational permutation of the current q, regardless of vld_d.
  - out_valid = vld_d. Latency: SEL_DELAY cycles.
- flush:
  - Clears every sel_valid stage and out_valid in the same edge.
  - A sel_valid asserted in the same cycle as flush is discarded.
  - sel/mode stages are not cleared.
  - u data is not cleared; with OUT_REG=1 it holds its value.
- Reset (async):
  - All delay-line stages go to 0, giving identity permutation (rotate by 0) and not-valid.
  - u register 0; out_valid 0.
  - With OUT_REG=0, u = q in identity order during and after reset until the first issued sel reaches the tap.
- Reset mid-stream: in-flight selects are lost. A new sel must be issued SEL_DELAY cycles before its data, with no carry-over.
- Back-to-back: a new sel/mode is accepted every cycle. Consecutive words may use different modes with no bubble.
- sel width is exactly log2(LANES); the rotate sum wraps modulo LANES through natural truncation.

Test Plan:
- LANES=4, SEL_DELAY=1, OUT_REG=1:
  - Issue sel=1, mode=0, sel_valid=1 at cycle 0; drive q={3:0x0D, 2:0x0C, 1:0x0B, 0:0x0A} at cycle 1.
  - Required at cycle 2: u={3:0x0A, 2:0x0D, 1:0x0C, 0:0x0B}, out_valid=1.
- Same q, sel=3, mode=1 -> u={3:0x0A, 2:0x0B, 1:0x0C, 0:0x0D}.
- Back-to-back:
  - Issue sel=0,1,2,3 (mode 0) on consecutive cycles with fixed q.
  - Required: u rotates by 0,1,2,3 on consecutive cycles, out_valid stays 1, no bubble.
- LANES=2, SEL_DELAY=1, OUT_REG=0:
  - sel=1 at cycle 0; q0=0x1234, q1=0x0567 at cycle 1.
  - Required same cycle: u0=0x0567, u1=0x1234 (legacy swap equivalence).
- SEL_DELAY=3:
  - Issue sel_valid=1 at cycle 0 and assert flush at cycle 2 -> out_valid never asserts for that select.
  - A sel_valid issued at cycle 3 -> out_valid=1 at cycle 7 (OUT_REG=1).
- Assert rst for one cycle mid-stream -> out_valid=0 and u=0 immediately.
  - Following cycles: permutation is identity until a new sel propagates; no stale select is applied.
